matrix_digit_scanner: RTL and testbench

//  Drives an 8-row x 4*N_DIGITS-column LED matrix from N_DIGITS seven-segment codes.

---
 rtl/matrix_digit_scanner.sv | 116 +++++++++++
 tb/tb_matrix_digit_scanner.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/matrix_digit_scanner.sv
// matrix_digit_scanner: scans N_DIGITS seven-segment codes onto an 8-row LED matrix
// with 4 columns per digit. Column slots are split into 16 PWM subslots. Subslot 0
// is always blank, to stop one column's rows bleeding into the next. Digit codes
// and brightness are latched once per frame so a frame is never torn.
module matrix_digit_scanner #(
    parameter int N_DIGITS   = 2,
    parameter int SUB_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [8*N_DIGITS-1:0] sevenseg_in,
    input  logic [3:0]            brightness,
    output logic [7:0]            row_n,
    output logic [4*N_DIGITS-1:0] col_n,
    output logic                  frame_start
);

    localparam int NCOLS = 4 * N_DIGITS;
    localparam int SC_W  = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;
    localparam int COL_W = $clog2(NCOLS);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SUB_CYCLES - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NCOLS - 1);

    logic [SC_W-1:0]         sub_cnt_q, sub_cnt_d;
    logic [3:0]              sub_idx_q, sub_idx_d;
    logic [COL_W-1:0]        col_idx_q, col_idx_d;
    logic [8*N_DIGITS-1:0]   seg_sh_q;
    logic [3:0]              bri_sh_q;
    logic [7:0]              row_n_q, row_n_d;
    logic [NCOLS-1:0]        col_n_q, col_n_d;
    logic                    frame_start_q;

    logic                    frame_load;
    logic                    lit;
    logic [NCOLS-1:0][7:0]   glyph;

    // Per-digit glyph: active-high row pattern for each of the digit's 4 columns.
    // Segment order in the code is {dp,g,f,e,d,c,b,a}; codes are active-low.
    for (genvar d = 0; d < N_DIGITS; d++) begin : g_digit
        logic [7:0] on;
        assign on = ~seg_sh_q[8*d +: 8];
        // left edge: f upper, e lower
        assign glyph[4*d+0] = {1'b0, 1'b0, on[4], on[4], 1'b0, on[5], on[5], 1'b0};
        // middle columns: a top, g centre, d bottom
        assign glyph[4*d+1] = {1'b0, on[3], 1'b0, 1'b0, on[6], 1'b0, 1'b0, on[0]};
        assign glyph[4*d+2] = {1'b0, on[3], 1'b0, 1'b0, on[6], 1'b0, 1'b0, on[0]};
        // right edge: b upper, c lower, dp in the bottom row
        assign glyph[4*d+3] = {on[7], 1'b0, on[2], on[2], 1'b0, on[1], on[1], 1'b0};
    end

    assign frame_load = enable && (sub_cnt_q == '0) && (sub_idx_q == '0) && (col_idx_q == '0);
    assign lit        = enable && (sub_idx_q != 4'd0) && (sub_idx_q <= bri_sh_q);

    // Next-state of the scan counters and the registered pin values.
    always_comb begin
        sub_cnt_d = '0;
        sub_idx_d = '0;
        col_idx_d = '0;
        if (enable) begin
            sub_cnt_d = (sub_cnt_q == SC_LAST) ? '0 : sub_cnt_q + 1'b1;
            sub_idx_d = sub_idx_q;
            col_idx_d = col_idx_q;
            if (sub_cnt_q == SC_LAST) begin
                sub_idx_d = sub_idx_q + 4'd1;
                if (sub_idx_q == 4'd15) begin
                    col_idx_d = (col_idx_q == COL_LAST) ? '0 : col_idx_q + 1'b1;
                end
            end
        end
        col_n_d = enable ? ~(NCOLS'(1) << col_idx_q) : '1;
        row_n_d = lit ? ~glyph[col_idx_q] : 8'hFF;
    end

    // Scan counters; held at zero while disabled so re-enable restarts the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_cnt_q <= '0;
            sub_idx_q <= '0;
            col_idx_q <= '0;
        end else begin
            sub_cnt_q <= sub_cnt_d;
            sub_idx_q <= sub_idx_d;
            col_idx_q <= col_idx_d;
        end
    end

    // Frame shadow registers: only refreshed on the frame-load cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_sh_q <= '1;
            bri_sh_q <= '0;
        end else if (frame_load) begin
            seg_sh_q <= sevenseg_in;
            bri_sh_q <= brightness;
        end
    end

    // Output registers, one cycle behind the counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_n_q       <= 8'hFF;
            col_n_q       <= '1;
            frame_start_q <= 1'b0;
        end else begin
            row_n_q       <= row_n_d;
            col_n_q       <= col_n_d;
            frame_start_q <= frame_load;
        end
    end

    assign row_n       = row_n_q;
    assign col_n       = col_n_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_matrix_digit_scanner.sv
// Scoreboard bench for matrix_digit_scanner: a frame-position model pushes the
// expected pin values every clock; a monitor pops and compares after each edge.
module tb_matrix_digit_scanner;

    localparam int ND    = 2;
    localparam int SUB   = 2;
    localparam int NC    = 4 * ND;
    localparam int SLOT  = 16 * SUB;
    localparam int FRAME = NC * SLOT;

    typedef struct packed {
        logic [7:0]    row;
        logic [NC-1:0] col;
        logic          fs;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic [8*ND-1:0] sevenseg_in;
    logic [3:0]      brightness;
    logic [7:0]      row_n;
    logic [NC-1:0]   col_n;
    logic            frame_start;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc_no = 0;
    exp_t        exp_q[$];

    matrix_digit_scanner #(.N_DIGITS(ND), .SUB_CYCLES(SUB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .sevenseg_in (sevenseg_in),
        .brightness  (brightness),
        .row_n       (row_n),
        .col_n       (col_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Which segment lights row r in column k of a glyph (-1 = none).
    function automatic int seg_of(int k, int r);
        case (k)
            0: case (r) 1, 2: return 5; 4, 5: return 4; default: return -1; endcase
            1, 2: case (r) 0: return 0; 3: return 6; 6: return 3; default: return -1; endcase
            default: case (r) 1, 2: return 1; 4, 5: return 2; 7: return 7; default: return -1; endcase
        endcase
    endfunction

    function automatic logic [7:0] ref_rows(int col, logic [8*ND-1:0] seg);
        logic [7:0] s;
        logic [7:0] rows;
        int si;
        s    = seg[8*(col/4) +: 8];
        rows = 8'h00;
        for (int r = 0; r < 8; r++) begin
            si = seg_of(col % 4, r);
            if (si >= 0 && s[si] == 1'b0) rows[r] = 1'b1;
        end
        return rows;
    endfunction

    // Reference model: position within the frame drives everything.
    int              m_pos = 0;
    logic [8*ND-1:0] m_seg = '1;
    logic [3:0]      m_bri = 4'd0;

    always @(posedge clk) begin
        exp_t e;
        int col, sub;
        e = '{row: 8'hFF, col: '1, fs: 1'b0};
        if (!rst_n) begin
            m_pos = 0;
            m_seg = '1;
            m_bri = 4'd0;
        end else if (!enable) begin
            m_pos = 0;
        end else begin
            col = m_pos / SLOT;
            sub = (m_pos / SUB) % 16;
            if (m_pos == 0) begin
                m_seg = sevenseg_in;
                m_bri = brightness;
                e.fs  = 1'b1;
            end
            if (sub != 0 && sub <= int'(m_bri)) e.row = ~ref_rows(col, m_seg);
            e.col = ~(NC'(1) << col);
            m_pos = (m_pos + 1) % FRAME;
        end
        exp_q.push_back(e);
    end

    // Monitor: outputs are registered, so compare just after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc_no++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (row_n !== e.row || col_n !== e.col || frame_start !== e.fs) begin
                n_bad++;
                $display("FAIL pins cyc%0d row/col/fs got %h/%h/%b want %h/%h/%b",
                         cyc_no, row_n, col_n, frame_start, e.row, e.col, e.fs);
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rand_inputs();
        sevenseg_in = 16'($urandom);
        brightness  = 4'($urandom);
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b1;
        sevenseg_in = 16'hFFFE;
        brightness  = 4'd15;
        cyc(4);
        rst_n = 1'b1;
        // a-only on digit 0 at full brightness
        cyc(FRAME + 3);
        sevenseg_in = 16'hFF80;
        brightness  = 4'd3;
        cyc(FRAME);
        // dark but still scanning
        sevenseg_in = 16'h0000;
        brightness  = 4'd0;
        cyc(2 * FRAME);
        // random inputs changing mid-frame
        repeat (14) begin
            rand_inputs();
            cyc($urandom_range(1, 200));
        end
        // enable drop mid column 5, restart after 10 cycles
        brightness  = 4'd15;
        sevenseg_in = 16'h0000;
        cyc(FRAME - (m_pos % FRAME) + 5 * SLOT + 7);
        enable = 1'b0;
        cyc(10);
        enable = 1'b1;
        cyc(FRAME + 20);
        // random enable toggling
        repeat (20) begin
            enable = ($urandom_range(0, 3) != 0);
            rand_inputs();
            cyc($urandom_range(1, 150));
        end
        enable = 1'b1;
        // asynchronous reset mid-frame must drop outputs at once
        repeat (2) begin
            cyc($urandom_range(40, 120));
            #2 rst_n = 1'b0;
            #1;
            n_cmp++;
            if (row_n !== 8'hFF || col_n !== '1 || frame_start !== 1'b0) begin
                n_bad++;
                $display("FAIL async_rst row/col/fs got %h/%h/%b want ff/ff/0",
                         row_n, col_n, frame_start);
            end
            cyc(3);
            rst_n = 1'b1;
            cyc(FRAME + 10);
        end
        cyc(3);
        n_cmp++;
        if (exp_q.size() > 1) begin
            n_bad++;
            $display("FAIL scoreboard_drain left %0d want <=1", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
